// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage types: ALU opcode enumeration and pipe entry sizing.
// alu_op_t is append-only; existing encodings must never be renumbered.
package riscv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD       = 5'd0,
    ALU_SUB       = 5'd1,
    ALU_SLL       = 5'd2,
    ALU_SLT       = 5'd3,
    ALU_SLTU      = 5'd4,
    ALU_XOR       = 5'd5,
    ALU_SRL       = 5'd6,
    ALU_SRA       = 5'd7,
    ALU_OR        = 5'd8,
    ALU_AND       = 5'd9,
    ALU_ADDW      = 5'd10,
    ALU_SUBW      = 5'd11,
    ALU_SLLW      = 5'd12,
    ALU_SRLW      = 5'd13,
    ALU_SRAW      = 5'd14,
    ALU_SH1ADD    = 5'd15,
    ALU_SH2ADD    = 5'd16,
    ALU_SH3ADD    = 5'd17,
    ALU_ADD_UW    = 5'd18,
    ALU_SH1ADD_UW = 5'd19,
    ALU_SH2ADD_UW = 5'd20,
    ALU_SH3ADD_UW = 5'd21,
    ALU_SLLI_UW   = 5'd22
  } alu_op_t;

  // Packed width of an alu_pipe_entry_t {result, tag, illegal}.
  function automatic int alu_entry_width(int xlen, int tag_w);
    return xlen + tag_w + 1;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One elastic register stage: holds a valid bit and an opaque payload.
// Loads whenever it is empty or its content is being taken downstream,
// so bubbles collapse even while the consumer stalls.
module alu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Valid/payload register; flush only kills the valid bit, data may stay stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      if (in_ready) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Elastic execute-stage integer ALU with STAGES register stages and a caller tag.
// Optional Zba support is enabled by defining ALU_PIPE_ZBA_EN; without it every
// Zba op is reported illegal and no Zba adders exist.
module alu_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } alu_pipe_entry_t;

  localparam int ENTRY_W = alu_entry_width(XLEN, TAG_W);
  localparam int SHW     = $clog2(XLEN);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("alu_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("alu_pipe: STAGES must be in 1..4");
  end

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] a_uw;
  logic [XLEN-1:0] res;
  logic [31:0]     w32;
  logic            w_op;
  logic            uw_op;
  logic            ill;
  alu_pipe_entry_t entry_in;

  assign shamt = in_b[SHW-1:0];
  assign a_uw  = XLEN'(in_a[31:0]);

  // Operation decode and compute; illegal ops always produce a zero result.
  always_comb begin
    res   = '0;
    w32   = '0;
    w_op  = 1'b0;
    uw_op = 1'b0;
    ill   = 1'b0;
    case (in_op)
      ALU_ADD:  res = in_a + in_b;
      ALU_SUB:  res = in_a - in_b;
      ALU_SLL:  res = in_a << shamt;
      ALU_SLT:  res = XLEN'($signed(in_a) < $signed(in_b));
      ALU_SLTU: res = XLEN'(in_a < in_b);
      ALU_XOR:  res = in_a ^ in_b;
      ALU_SRL:  res = in_a >> shamt;
      ALU_SRA:  res = $signed(in_a) >>> shamt;
      ALU_OR:   res = in_a | in_b;
      ALU_AND:  res = in_a & in_b;
      ALU_ADDW: begin w_op = 1'b1; w32 = in_a[31:0] + in_b[31:0]; end
      ALU_SUBW: begin w_op = 1'b1; w32 = in_a[31:0] - in_b[31:0]; end
      ALU_SLLW: begin w_op = 1'b1; w32 = in_a[31:0] << in_b[4:0]; end
      ALU_SRLW: begin w_op = 1'b1; w32 = in_a[31:0] >> in_b[4:0]; end
      ALU_SRAW: begin w_op = 1'b1; w32 = $signed(in_a[31:0]) >>> in_b[4:0]; end
`ifdef ALU_PIPE_ZBA_EN
      ALU_SH1ADD:    res = in_b + (in_a << 1);
      ALU_SH2ADD:    res = in_b + (in_a << 2);
      ALU_SH3ADD:    res = in_b + (in_a << 3);
      ALU_ADD_UW:    begin uw_op = 1'b1; res = in_b + a_uw; end
      ALU_SH1ADD_UW: begin uw_op = 1'b1; res = in_b + (a_uw << 1); end
      ALU_SH2ADD_UW: begin uw_op = 1'b1; res = in_b + (a_uw << 2); end
      ALU_SH3ADD_UW: begin uw_op = 1'b1; res = in_b + (a_uw << 3); end
      ALU_SLLI_UW:   begin uw_op = 1'b1; res = a_uw << shamt; end
`else
      ALU_SH1ADD, ALU_SH2ADD, ALU_SH3ADD, ALU_ADD_UW, ALU_SH1ADD_UW,
      ALU_SH2ADD_UW, ALU_SH3ADD_UW, ALU_SLLI_UW: ill = 1'b1;
`endif
      default: ill = 1'b1;
    endcase
    if (w_op) begin
      if (XLEN == 64) begin
        res = XLEN'($signed(w32));
      end else begin
        ill = 1'b1;
      end
    end
    if (uw_op && XLEN != 64) begin
      ill = 1'b1;
    end
    if (ill) begin
      res = '0;
    end
  end

  assign entry_in = '{result: res, tag: in_tag, illegal: ill};

  logic [STAGES-1:0] s_valid;
  logic [STAGES-1:0] s_ready;
  alu_pipe_entry_t   s_q [STAGES];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic            up_valid;
    alu_pipe_entry_t up_data;
    logic            down_ready;

    if (gi == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = entry_in;
    end else begin : g_mid
      assign up_valid = s_valid[gi-1];
      assign up_data  = s_q[gi-1];
    end

    if (gi == STAGES - 1) begin : g_last
      assign down_ready = out_ready;
    end else begin : g_inner
      assign down_ready = s_ready[gi+1];
    end

    alu_pipe_stage #(.W(ENTRY_W)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (up_valid),
      .in_ready  (s_ready[gi]),
      .in_data   (up_data),
      .out_valid (s_valid[gi]),
      .out_ready (down_ready),
      .out_data  (s_q[gi])
    );
  end

  assign in_ready    = s_ready[0] && !flush;
  assign out_valid   = s_valid[STAGES-1];
  assign out_result  = s_q[STAGES-1].result;
  assign out_tag     = s_q[STAGES-1].tag;
  assign out_illegal = s_q[STAGES-1].illegal;

endmodule
